note_sprite_fetch: RTL and testbench

- Per-pixel sprite fetch stage for the 40x40 note sprites in GuitarZero.
- Takes the VGA scan position (DrawX/DrawY) and the note position, which is latched once per frame.
- Computes the linear read address for the downstream 24-bit sprite ROM (13-bit address, one-cycle registered read).
- Re-aligns ROM data with the hit flag, applies colour-key transparency, and presents pixel_on/pixel_rgb to the colour mapper.

---
 rtl/note_sprite_fetch.sv | 83 ++++++++
 tb/tb_note_sprite_fetch.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/note_sprite_fetch.sv
// Per-pixel fetch stage for the note sprites: hit test and ROM address generation,
// then realignment of the ROM data with the hit flag and colour-key transparency.
module note_sprite_fetch #(
    parameter int unsigned SPR_W   = 40,
    parameter int unsigned SPR_H   = 40,
    parameter logic [23:0] KEY_RGB = 24'hFF00FF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        note_en,
    input  logic [9:0]  note_x,
    input  logic [9:0]  note_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [12:0] read_address,
    input  logic [23:0] rom_data,
    output logic        pixel_on,
    output logic [23:0] pixel_rgb
);

    localparam int unsigned XW   = 10;
    localparam int unsigned SW   = 11;
    localparam int unsigned AW   = 13;
    localparam int unsigned RGBW = 24;

    logic [XW-1:0] lat_x;
    logic [XW-1:0] lat_y;
    logic          lat_en;
    logic          hit;
    logic          hit_d1;
    logic          hit_d2;
    logic [XW-1:0] dx;
    logic [XW-1:0] dy;
    logic [AW-1:0] addr;

    // Note position is sampled only on frame_start so a frame never tears
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lat_x  <= '0;
            lat_y  <= '0;
            lat_en <= 1'b0;
        end else if (frame_start) begin
            lat_x  <= note_x;
            lat_y  <= note_y;
            lat_en <= note_en;
        end
    end

    // Stage 0: hit test in 11 bits so the right/bottom bound never wraps
    always_comb begin
        hit = lat_en
            && (SW'(DrawX) >= SW'(lat_x))
            && (SW'(DrawX) <  SW'(lat_x) + SW'(SPR_W))
            && (SW'(DrawY) >= SW'(lat_y))
            && (SW'(DrawY) <  SW'(lat_y) + SW'(SPR_H));
        dx   = DrawX - lat_x;
        dy   = DrawY - lat_y;
        addr = '0;
        if (hit) begin
            addr = AW'(AW'(dy) * AW'(SPR_W)) + AW'(dx);
        end
    end

    // Stage 1 presents the address; stage 2 lines the hit up with the ROM's registered data
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            hit_d1       <= 1'b0;
            hit_d2       <= 1'b0;
        end else begin
            read_address <= addr;
            hit_d1       <= hit;
            hit_d2       <= hit_d1;
        end
    end

    always_comb begin
        pixel_on  = hit_d2 && (rom_data != KEY_RGB);
        pixel_rgb = pixel_on ? rom_data : RGBW'(0);
    end

endmodule

// File: tb/tb_note_sprite_fetch.sv
// Scoreboard bench for note_sprite_fetch with a registered-read ROM model.
module tb_note_sprite_fetch;

    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start;
    logic        note_en;
    logic [9:0]  note_x;
    logic [9:0]  note_y;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [12:0] read_address;
    logic [23:0] rom_data;
    logic        pixel_on;
    logic [23:0] pixel_rgb;

    int passed = 0;
    int total  = 0;

    logic        frc_en, frc_en_d;
    logic [23:0] frc_val, frc_val_d;

    int m_lx, m_ly;
    bit m_en;

    logic [12:0] addr_q[$];
    logic [24:0] pix_q[$];

    note_sprite_fetch dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .note_en      (note_en),
        .note_x       (note_x),
        .note_y       (note_y),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .read_address (read_address),
        .rom_data     (rom_data),
        .pixel_on     (pixel_on),
        .pixel_rgb    (pixel_rgb)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] pat(input logic [12:0] a);
        return {3'b000, a, 8'h3C};
    endfunction

    // ROM model: one-cycle registered read, with a per-sample override for key tests
    always @(posedge Clk) begin
        frc_en_d  <= frc_en;
        frc_val_d <= frc_val;
        if (!Reset_n)      rom_data <= 24'h123456;
        else if (frc_en_d) rom_data <= frc_val_d;
        else               rom_data <= pat(read_address);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        logic [12:0] a;
        logic [24:0] p;
        if (addr_q.size() > 0) begin
            a = addr_q.pop_front();
            check("read_address", 32'(read_address), 32'(a));
        end
        if (pix_q.size() >= 2) begin
            p = pix_q.pop_front();
            check("pixel_on", 32'(pixel_on), 32'(p[24]));
            check("pixel_rgb", 32'(pixel_rgb), 32'(p[23:0]));
        end
    endtask

    task automatic drive_push(input int x, input int y, input bit fs,
                              input bit fe, input logic [23:0] fv);
        bit          h;
        logic [12:0] a;
        logic [23:0] rom;
        bit          on;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        frame_start = fs;
        frc_en      = fe;
        frc_val     = fv;
        h = m_en && x >= m_lx && x < m_lx + 40 && y >= m_ly && y < m_ly + 40;
        a = h ? 13'((y - m_ly) * 40 + (x - m_lx)) : 13'd0;
        rom = fe ? fv : pat(a);
        on = h && (rom != KEY);
        addr_q.push_back(a);
        pix_q.push_back({on, on ? rom : 24'h0});
        if (fs) begin
            m_lx = int'(note_x);
            m_ly = int'(note_y);
            m_en = note_en;
        end
    endtask

    task automatic step(input int x, input int y, input bit fs = 1'b0,
                        input bit fe = 1'b0, input logic [23:0] fv = 24'h0);
        @(negedge Clk);
        check_outputs();
        drive_push(x, y, fs, fe, fv);
    endtask

    initial begin
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        note_en     = 1'b0;
        note_x      = '0;
        note_y      = '0;
        DrawX       = '0;
        DrawY       = '0;
        frc_en      = 1'b0;
        frc_val     = '0;
        m_lx = 0; m_ly = 0; m_en = 1'b0;

        repeat (3) @(negedge Clk);
        check("rst_rom_data", 32'(rom_data), 32'h123456);
        check("rst_pixel_on", 32'(pixel_on), 32'h0);
        check("rst_pixel_rgb", 32'(pixel_rgb), 32'h0);
        check("rst_read_address", 32'(read_address), 32'h0);
        Reset_n = 1'b1;

        note_x = 10'd100; note_y = 10'd50; note_en = 1'b1;
        step(0, 0, 1'b1);
        step(100, 50);
        step(139, 89);
        step(99, 50);
        step(140, 50);
        step(100, 90);
        step(110, 50, 1'b0, 1'b1, KEY);
        step(110, 50, 1'b0, 1'b1, 24'h0000FF);
        step(120, 70);

        // Moving the note without frame_start must not affect this frame
        note_x = 10'd300;
        step(100, 50);
        step(0, 0, 1'b1);
        step(300, 50);
        step(100, 50);
        step(300, 50, 1'b1);
        step(339, 89);

        note_x = 10'd620;
        step(0, 0, 1'b1);
        step(639, 50);
        for (int i = 630; i < 634; i++) step(i, 60);

        // Mid-run reset: pipeline flushes and latched position clears
        @(negedge Clk);
        check_outputs();
        Reset_n = 1'b0;
        #1;
        check("midrst_pixel_on", 32'(pixel_on), 32'h0);
        check("midrst_pixel_rgb", 32'(pixel_rgb), 32'h0);
        check("midrst_read_address", 32'(read_address), 32'h0);
        addr_q.delete();
        pix_q.delete();
        m_lx = 0; m_ly = 0; m_en = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        drive_push(634, 60, 1'b1, 1'b0, 24'h0);
        for (int i = 635; i < 640; i++) step(i, 60);

        note_en = 1'b0;
        step(0, 0, 1'b1);
        step(625, 50);
        step(639, 89);
        step(0, 0);
        step(0, 0);
        step(0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
